// File: rtl/match_controller.sv
// Round/match sequencer above game_core: countdown, health tracking, round timer,
// KO freeze and round counting. All game-time counting advances on SCEN only.
module match_controller #(
  parameter int unsigned MAX_HP           = 100,
  parameter int unsigned DMG              = 10,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned FRAMES_PER_SEC   = 60,
  parameter int unsigned ROUND_SECS       = 99,
  parameter int unsigned KO_FRAMES        = 120,
  parameter int unsigned ROUNDS_TO_WIN    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       start,
  input  logic       p1_hit_event,
  input  logic       p2_hit_event,
  output logic       core_reset,
  output logic       input_enable,
  output logic [2:0] state,
  output logic [7:0] p1_hp,
  output logic [7:0] p2_hp,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [6:0] round_timer,
  output logic [1:0] countdown,
  output logic [1:0] winner
);

  localparam int unsigned CD_STEP   = COUNTDOWN_FRAMES / 3;
  localparam int unsigned FRAME_MAX = (CD_STEP > KO_FRAMES) ? CD_STEP : KO_FRAMES;
  localparam int unsigned FW        = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;
  localparam int unsigned SW        = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  localparam logic [7:0]    HP_INIT    = 8'(MAX_HP);
  localparam logic [7:0]    DMG8       = 8'(DMG);
  localparam logic [6:0]    TIMER_INIT = 7'(ROUND_SECS);
  localparam logic [1:0]    RTW        = 2'(ROUNDS_TO_WIN);
  localparam logic [FW-1:0] CD_LAST    = FW'(CD_STEP - 1);
  localparam logic [FW-1:0] KO_LAST    = FW'(KO_FRAMES - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(FRAMES_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_FIGHT      = 3'd2,
    S_KO         = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_t;

  state_t        st;
  logic          start_q;
  logic [FW-1:0] frame_cnt;
  logic [SW-1:0] sec_cnt;

  logic          start_rise;
  logic [7:0]    p1_hp_nx;
  logic [7:0]    p2_hp_nx;
  logic [6:0]    timer_nx;
  logic          sec_wrap;
  logic          round_over;
  logic [1:0]    result;
  logic          ko_done;
  logic          match_won;
  logic          enter_cd;

  assign state = st;

  function automatic logic [7:0] take_hit(input logic [7:0] hp);
    return (hp > DMG8) ? hp - DMG8 : '0;
  endfunction

  // Round end is judged on the values the FIGHT edge is about to store,
  // so a hit or timeout on the deciding cycle is always counted.
  always_comb begin
    start_rise = start & ~start_q;
    p1_hp_nx   = p2_hit_event ? take_hit(p1_hp) : p1_hp;
    p2_hp_nx   = p1_hit_event ? take_hit(p2_hp) : p2_hp;
    sec_wrap   = SCEN && (sec_cnt == SEC_LAST);
    timer_nx   = round_timer;
    if (sec_wrap && (round_timer != '0))
      timer_nx = round_timer - 7'd1;
    round_over = (p1_hp_nx == '0) || (p2_hp_nx == '0) || (timer_nx == '0);
    if (p1_hp_nx > p2_hp_nx)
      result = 2'd1;
    else if (p1_hp_nx < p2_hp_nx)
      result = 2'd2;
    else
      result = 2'd3;
    ko_done   = SCEN && (frame_cnt == KO_LAST);
    match_won = (p1_rounds >= RTW) || (p2_rounds >= RTW);
    enter_cd  = (((st == S_IDLE) || (st == S_MATCH_OVER)) && start_rise) ||
                ((st == S_KO) && ko_done && !match_won);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= S_IDLE;
      start_q      <= 1'b0;
      frame_cnt    <= '0;
      sec_cnt      <= '0;
      core_reset   <= 1'b1;
      input_enable <= 1'b0;
      p1_hp        <= HP_INIT;
      p2_hp        <= HP_INIT;
      p1_rounds    <= '0;
      p2_rounds    <= '0;
      round_timer  <= TIMER_INIT;
      countdown    <= 2'd3;
      winner       <= '0;
    end else begin
      start_q <= start;
      case (st)
        S_IDLE: begin
          if (start_rise)
            st <= S_COUNTDOWN;
        end
        S_COUNTDOWN: begin
          if (SCEN) begin
            if (frame_cnt == CD_LAST) begin
              frame_cnt <= '0;
              if (countdown == 2'd1) begin
                st           <= S_FIGHT;
                countdown    <= 2'd3;
                sec_cnt      <= '0;
                core_reset   <= 1'b0;
                input_enable <= 1'b1;
              end else begin
                countdown <= countdown - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
        end
        S_FIGHT: begin
          p1_hp       <= p1_hp_nx;
          p2_hp       <= p2_hp_nx;
          round_timer <= timer_nx;
          if (SCEN)
            sec_cnt <= sec_wrap ? '0 : sec_cnt + SW'(1);
          if (round_over) begin
            st           <= S_KO;
            input_enable <= 1'b0;
            winner       <= result;
            frame_cnt    <= '0;
            sec_cnt      <= '0;
            if ((result == 2'd1) && (p1_rounds != 2'd3))
              p1_rounds <= p1_rounds + 2'd1;
            if ((result == 2'd2) && (p2_rounds != 2'd3))
              p2_rounds <= p2_rounds + 2'd1;
          end
        end
        S_KO: begin
          if (ko_done) begin
            frame_cnt <= '0;
            if (match_won) begin
              st         <= S_MATCH_OVER;
              core_reset <= 1'b1;
            end else begin
              st <= S_COUNTDOWN;
            end
          end else if (SCEN) begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end
        S_MATCH_OVER: begin
          if (start_rise) begin
            st        <= S_COUNTDOWN;
            p1_rounds <= '0;
            p2_rounds <= '0;
            winner    <= '0;
          end
        end
        default: st <= S_IDLE;
      endcase
      // Every path into COUNTDOWN shares the same round reload.
      if (enter_cd) begin
        p1_hp        <= HP_INIT;
        p2_hp        <= HP_INIT;
        round_timer  <= TIMER_INIT;
        countdown    <= 2'd3;
        frame_cnt    <= '0;
        sec_cnt      <= '0;
        core_reset   <= 1'b1;
        input_enable <= 1'b0;
      end
    end
  end

endmodule

// File: doc/match_controller.md
# match_controller

Round/match sequencer for the fighting game. Sits above `game_core`, driving its reset and gating P1/P2 button inputs. Tracks health from the resolver's hit events, runs the countdown, round timer and KO pause, and counts rounds to a match winner. All game-time counting advances only on the `SCEN` frame tick.

## Interface

- `MAX_HP`, 100: starting health per round (≤255).
- `DMG`, 10: health removed per hit event.
- `COUNTDOWN_FRAMES`, 180: pre-round frames; must be a multiple of 3.
- `FRAMES_PER_SEC`, 60: SCEN ticks per timer second.
- `ROUND_SECS`, 99: round timer start value (≤127).
- `KO_FRAMES`, 120: post-round freeze frames.
- `ROUNDS_TO_WIN`, 2: rounds needed for match (1–3).

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `SCEN` in 1: one-`clk` frame tick.
- `start` in 1: start button, level; rising edge used.
- `p1_hit_event` in 1: P1 struck P2 this cycle.
- `p2_hit_event` in 1: P2 struck P1 this cycle.
- `core_reset` out 1: reset to `game_core`.
- `input_enable` out 1: AND-gate for all player buttons.
- `state` out 3: IDLE=0, COUNTDOWN=1, FIGHT=2, KO=3, MATCH_OVER=4.
- `p1_hp`, `p2_hp` out 8: current health.
- `p1_rounds`, `p2_rounds` out 2: rounds won.
- `round_timer` out 7: seconds remaining.
- `countdown` out 2: 3/2/1 display digit.
- `winner` out 2: last round result; 0 none, 1 P1, 2 P2, 3 draw.

## Operation

- Start edge: `start` registered each `clk`; `start_rise = start & ~start_q`.
- IDLE:
  - Outputs: `core_reset`=1, `input_enable`=0, hp=MAX_HP, rounds=0, `round_timer`=ROUND_SECS, `countdown`=3, `winner`=0.
  - `start_rise` → COUNTDOWN.
- COUNTDOWN:
  - Outputs: `core_reset`=1, `input_enable`=0.
  - On entry: hp reload MAX_HP, timer reload ROUND_SECS, `countdown`=3, frame counter cleared.
  - Every COUNTDOWN_FRAMES/3 SCEN ticks, `countdown` decrements.
  - On the SCEN that completes digit 1 → FIGHT, and `countdown` reloads 3.
- FIGHT:
  - Outputs: `core_reset`=0, `input_enable`=1.
  - `p1_hit_event` high on any `clk`: `p2_hp` -= DMG, saturating at 0. `p2_hit_event` reduces `p1_hp` the same way. Both may apply in the same cycle.
  - Second prescaler counts SCEN 0..FRAMES_PER_SEC-1. At wrap, `round_timer` decrements, saturating at 0.
  - Round end: evaluated on next-state values (post-hit hp, post-decrement timer) at the same edge. Condition is next `p1_hp`==0, next `p2_hp`==0, or next timer==0 → KO.
  - Result latched into `winner`: higher next hp wins; equal hp is a draw (3).
  - Winner's rounds counter increments, saturating at 3. A draw awards nothing.
- KO:
  - Outputs: `input_enable`=0, `core_reset`=0. Hits ignored; hp and timer frozen.
  - After KO_FRAMES SCEN ticks: if either rounds counter ≥ ROUNDS_TO_WIN → MATCH_OVER, else → COUNTDOWN.
- MATCH_OVER:
  - Outputs: `input_enable`=0, `core_reset`=1. hp, rounds and `winner` held.
  - `start_rise` → COUNTDOWN, with rounds cleared, `winner`=0, `start_q` history kept.
- All frame/second counters clear on every state entry.
- Asynchronous `reset` at any point forces IDLE reset values immediately, including mid-round and mid-KO.

## Timing

- All outputs are registered; `core_reset` and `input_enable` are decoded from registered state.
- Latencies:
  - `start` rising → `state`=COUNTDOWN: 1 `clk` after `start_q` sees the edge, i.e. the edge after `start` rises.
  - Hit pulse at cycle N → hp updated at edge N+1. If that update ends the round, `state`=KO at the same edge.
  - Timer decrement and timeout: same edge as the FRAMES_PER_SEC-th SCEN.
- COUNTDOWN lasts exactly COUNTDOWN_FRAMES SCEN ticks. KO lasts exactly KO_FRAMES SCEN ticks.
- Hit event coinciding with the FIGHT→KO edge: applied, because the state was still FIGHT.
- Hit event in a KO cycle: dropped.
- Simultaneous hit and timeout: both applied, then result by hp comparison.
- Draw rounds can extend the match indefinitely. This is required behaviour.

## Test plan

Bench parameters: MAX_HP=30, DMG=10, COUNTDOWN_FRAMES=6, FRAMES_PER_SEC=4, ROUND_SECS=5, KO_FRAMES=3, ROUNDS_TO_WIN=2. SCEN every 4th `clk`.

- **Reset/start:**
  - After reset: `state`=0, `core_reset`=1, hp=30/30, timer=5, `countdown`=3.
  - Pulse `start`: `state`=1 one edge after `start_q` sees the rise, i.e. the edge after `start` rises.
  - `countdown` goes 3,2,1 at 2-SCEN intervals; `state`=2 after the 6th SCEN.
  - `input_enable`=1 and `core_reset`=0 in FIGHT.
- **KO:** 3 single-cycle `p1_hit_event` pulses → `p2_hp` 20,10,0.
  - `state`=3 and `winner`=1 at the 3rd update edge; `p1_rounds`=1.
  - After 3 SCEN: `state`=1 and hp reloads 30/30.
- **Simultaneous trade:** with both hp=10, assert both hit events in one cycle → both hp=0, `winner`=3, no round awarded.
- **Timeout:**
  - No hits, `p2_hp` pre-reduced to 20.
  - `round_timer` counts 5→0 over 20 SCEN; at 0, `state`=3 and `winner`=1.
  - A hit during KO leaves hp unchanged.
- **Match over:**
  - P2 wins two rounds → `state`=4, `p2_rounds`=2, `core_reset`=1.
  - Holding `start` high does nothing; a new rising edge → COUNTDOWN with rounds=0/0.
- **Async reset mid-FIGHT:** assert `reset` between clock edges → outputs at IDLE values before the next `clk` edge.
